// File: rtl/llc_update_way_pkg.sv
// Shared LLC cache types and constants used by the update-way engine.
// Also defines the three-state FSM encoding for the engine.
package llc_update_way_pkg;

   localparam int LLC_SET_BITS   = 8;
   localparam int LLC_WAYS       = 8;
   localparam int LLC_WAY_BITS   = $clog2(LLC_WAYS);
   localparam int LLC_TAG_BITS   = 12;
   localparam int LLC_STATE_BITS = 2;

   typedef logic [LLC_SET_BITS-1:0]   llc_set_t;
   typedef logic [LLC_WAY_BITS-1:0]   llc_way_t;
   typedef logic [LLC_TAG_BITS-1:0]   llc_tag_t;
   typedef logic [LLC_STATE_BITS-1:0] llc_state_t;

   localparam llc_state_t INVALID = 2'd0;
   localparam llc_state_t VALID   = 2'd1;
   localparam llc_state_t SD      = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      MEM_WR = 2'd2
   } upd_fsm_t;

endpackage

// File: rtl/llc_update_way.sv
// Drains the LLC update FIFO: writes tag/state buffers, advances the eviction
// way on evictions, then writes the tag/state SRAM through a ready/valid channel.
module llc_update_way
   import llc_update_way_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty_update,
   output logic       fifo_pop_update,
   input  llc_set_t   upd_set,
   input  llc_way_t   upd_way,
   input  logic       upd_evict,
   input  llc_tag_t   upd_tag,
   input  llc_state_t upd_state,
   output logic       wr_en_bufs,
   output llc_way_t   wr_way,
   output llc_tag_t   wr_tag,
   output llc_state_t wr_state,
   output logic       wr_en_evict_way,
   output llc_way_t   evict_way_wr,
   output logic       mem_wr_valid,
   input  logic       mem_wr_ready,
   output llc_set_t   mem_wr_set,
   output llc_way_t   mem_wr_way,
   output llc_tag_t   mem_wr_tag,
   output llc_state_t mem_wr_state,
   output logic       update_done,
   output logic       busy
);

   upd_fsm_t   r_state;
   upd_fsm_t   w_next_state;
   llc_set_t   r_set;
   llc_way_t   r_way;
   logic       r_evict;
   llc_tag_t   r_tag;
   llc_state_t r_upd_state;
   logic       w_pop;
   llc_way_t   w_evict_way;

   // The FSM rests in IDLE during reset, so the pop is also gated by rst to keep it low then.
   assign w_pop = (r_state == IDLE) && !fifo_empty_update && rst;

   assign w_evict_way = (r_way == LLC_WAY_BITS'(LLC_WAYS - 1)) ? '0 : (r_way + LLC_WAY_BITS'(1));

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_pop) w_next_state = UPDATE;
            else       w_next_state = IDLE;
         end
         UPDATE: w_next_state = MEM_WR;
         MEM_WR: begin
            if (mem_wr_ready) w_next_state = IDLE;
            else              w_next_state = MEM_WR;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Capture the FIFO head on pop; held for the whole update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_set       <= '0;
         r_way       <= '0;
         r_evict     <= 1'b0;
         r_tag       <= '0;
         r_upd_state <= INVALID;
      end else if (w_pop) begin
         r_set       <= upd_set;
         r_way       <= upd_way;
         r_evict     <= upd_evict;
         r_tag       <= upd_tag;
         r_upd_state <= upd_state;
      end else begin
         r_set       <= r_set;
         r_way       <= r_way;
         r_evict     <= r_evict;
         r_tag       <= r_tag;
         r_upd_state <= r_upd_state;
      end
   end

   // Output decode from state; fields are zero outside their strobe phase
   always_comb begin
      fifo_pop_update = w_pop;
      wr_en_bufs      = 1'b0;
      wr_way          = '0;
      wr_tag          = '0;
      wr_state        = INVALID;
      wr_en_evict_way = 1'b0;
      evict_way_wr    = '0;
      mem_wr_valid    = 1'b0;
      mem_wr_set      = '0;
      mem_wr_way      = '0;
      mem_wr_tag      = '0;
      mem_wr_state    = INVALID;
      update_done     = 1'b0;
      busy            = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
         end
         UPDATE: begin
            busy       = 1'b1;
            wr_en_bufs = 1'b1;
            wr_way     = r_way;
            wr_tag     = r_tag;
            wr_state   = r_upd_state;
            if (r_evict) begin
               wr_en_evict_way = 1'b1;
               evict_way_wr    = w_evict_way;
            end else begin
               wr_en_evict_way = 1'b0;
               evict_way_wr    = '0;
            end
         end
         MEM_WR: begin
            busy         = 1'b1;
            mem_wr_valid = 1'b1;
            mem_wr_set   = r_set;
            mem_wr_way   = r_way;
            mem_wr_tag   = r_tag;
            mem_wr_state = r_upd_state;
            update_done  = mem_wr_ready;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_llc_update_way.sv
// Randomized plus directed bench for llc_update_way against a transaction-level
// model: each popped entry expects a buffer write one cycle later, then a held writeback.
module tb_llc_update_way;
   import llc_update_way_pkg::*;

   typedef struct packed {
      llc_set_t   set;
      llc_way_t   way;
      logic       evict;
      llc_tag_t   tag;
      llc_state_t state;
   } entry_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fifo_empty_update;
   logic       fifo_pop_update;
   llc_set_t   upd_set;
   llc_way_t   upd_way;
   logic       upd_evict;
   llc_tag_t   upd_tag;
   llc_state_t upd_state;
   logic       wr_en_bufs;
   llc_way_t   wr_way;
   llc_tag_t   wr_tag;
   llc_state_t wr_state;
   logic       wr_en_evict_way;
   llc_way_t   evict_way_wr;
   logic       mem_wr_valid;
   logic       mem_wr_ready = 1'b0;
   llc_set_t   mem_wr_set;
   llc_way_t   mem_wr_way;
   llc_tag_t   mem_wr_tag;
   llc_state_t mem_wr_state;
   logic       update_done;
   logic       busy;

   llc_update_way dut (
      .clk(clk), .rst(rst),
      .fifo_empty_update(fifo_empty_update), .fifo_pop_update(fifo_pop_update),
      .upd_set(upd_set), .upd_way(upd_way), .upd_evict(upd_evict),
      .upd_tag(upd_tag), .upd_state(upd_state),
      .wr_en_bufs(wr_en_bufs), .wr_way(wr_way), .wr_tag(wr_tag), .wr_state(wr_state),
      .wr_en_evict_way(wr_en_evict_way), .evict_way_wr(evict_way_wr),
      .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
      .mem_wr_set(mem_wr_set), .mem_wr_way(mem_wr_way),
      .mem_wr_tag(mem_wr_tag), .mem_wr_state(mem_wr_state),
      .update_done(update_done), .busy(busy)
   );

   always #5 clk = ~clk;

   entry_t fifo_q[$];
   int     checks = 0;
   int     errors = 0;

   // model of the single in-flight update
   bit     have_txn = 1'b0;
   entry_t cur;
   int     t_pop = 0;
   int     cyc = 0;

   // DUT-observed event counts
   int     dut_pops = 0;
   int     dut_dones = 0;
   int     dut_pop_cyc[$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic entry_t rand_entry();
      entry_t e;
      e.set   = llc_set_t'($urandom);
      e.way   = llc_way_t'($urandom_range(0, LLC_WAYS - 1));
      e.evict = 1'($urandom_range(0, 1));
      e.tag   = llc_tag_t'($urandom);
      e.state = llc_state_t'($urandom_range(0, 2));
      return e;
   endfunction

   task automatic drive_head();
      fifo_empty_update = (fifo_q.size() == 0);
      if (fifo_q.size() != 0) begin
         upd_set   = fifo_q[0].set;
         upd_way   = fifo_q[0].way;
         upd_evict = fifo_q[0].evict;
         upd_tag   = fifo_q[0].tag;
         upd_state = fifo_q[0].state;
      end else begin
         upd_set   = llc_set_t'($urandom);
         upd_way   = llc_way_t'($urandom);
         upd_evict = 1'($urandom);
         upd_tag   = llc_tag_t'($urandom);
         upd_state = llc_state_t'($urandom);
      end
   endtask

   task automatic push(input entry_t e);
      fifo_q.push_back(e);
      drive_head();
   endtask

   task automatic check_all_zero(input string tag);
      chk(tag, {fifo_pop_update, wr_en_bufs, wr_way, wr_tag, wr_state, wr_en_evict_way,
                evict_way_wr, mem_wr_valid, mem_wr_set, mem_wr_way, mem_wr_tag,
                mem_wr_state, update_done, busy}, 64'd0);
   endtask

   // One clock: check outputs at negedge, advance model and FIFO just after posedge
   task automatic cycle();
      bit exp_pop, exp_wr, exp_valid, exp_done;
      @(negedge clk);
      exp_pop   = !have_txn && (fifo_q.size() != 0);
      exp_wr    = have_txn && (cyc == t_pop + 1);
      exp_valid = have_txn && (cyc >= t_pop + 2);
      exp_done  = exp_valid && mem_wr_ready;
      chk("pop", 64'(fifo_pop_update), 64'(exp_pop));
      chk("wr_en_bufs", 64'(wr_en_bufs), 64'(exp_wr));
      chk("wr_en_evict_way", 64'(wr_en_evict_way), 64'(exp_wr && cur.evict));
      chk("mem_wr_valid", 64'(mem_wr_valid), 64'(exp_valid));
      chk("update_done", 64'(update_done), 64'(exp_done));
      chk("busy", 64'(busy), 64'(have_txn));
      if (exp_wr) begin
         chk("wr_way", 64'(wr_way), 64'(cur.way));
         chk("wr_tag", 64'(wr_tag), 64'(cur.tag));
         chk("wr_state", 64'(wr_state), 64'(cur.state));
         if (cur.evict) chk("evict_way_wr", 64'(evict_way_wr), 64'((int'(cur.way) + 1) % LLC_WAYS));
      end
      if (exp_valid) begin
         chk("mem_wr_set", 64'(mem_wr_set), 64'(cur.set));
         chk("mem_wr_way", 64'(mem_wr_way), 64'(cur.way));
         chk("mem_wr_tag", 64'(mem_wr_tag), 64'(cur.tag));
         chk("mem_wr_state", 64'(mem_wr_state), 64'(cur.state));
      end
      if (fifo_pop_update) begin
         dut_pops++;
         dut_pop_cyc.push_back(cyc);
      end
      if (update_done) dut_dones++;
      @(posedge clk);
      #1;
      if (exp_pop) begin
         cur      = fifo_q.pop_front();
         have_txn = 1'b1;
         t_pop    = cyc;
      end
      if (exp_done) have_txn = 1'b0;
      cyc++;
      drive_head();
   endtask

   initial begin
      int p0, d0;
      entry_t e;
      drive_head();
      #2;
      check_all_zero("reset_outputs");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // hit update, ready already high: pop c0, write c1, done c2
      e.set = 8'd5; e.way = 3'd2; e.evict = 1'b0; e.tag = 12'h3a5; e.state = VALID;
      mem_wr_ready = 1'b1;
      p0 = dut_pops; d0 = dut_dones;
      push(e);
      repeat (4) cycle();
      chk("hit_pops", 64'(dut_pops - p0), 64'd1);
      chk("hit_dones", 64'(dut_dones - d0), 64'd1);

      // eviction from the last way wraps to way 0
      e.set = 8'd9; e.way = llc_way_t'(LLC_WAYS - 1); e.evict = 1'b1; e.tag = 12'h0f0; e.state = SD;
      push(e);
      repeat (4) cycle();

      // backpressure: ready low for 4 writeback cycles, second entry must wait
      mem_wr_ready = 1'b0;
      p0 = dut_pops; d0 = dut_dones;
      push(rand_entry());
      push(rand_entry());
      repeat (6) cycle();
      chk("bp_single_pop", 64'(dut_pops - p0), 64'd1);
      chk("bp_no_done", 64'(dut_dones - d0), 64'd0);
      mem_wr_ready = 1'b1;
      cycle();
      chk("bp_one_done", 64'(dut_dones - d0), 64'd1);
      repeat (4) cycle();

      // back-to-back: three queued entries, pops spaced 3 cycles apart
      p0 = dut_pops; d0 = dut_dones;
      dut_pop_cyc.delete();
      for (int i = 0; i < 3; i++) push(rand_entry());
      repeat (10) cycle();
      chk("b2b_pops", 64'(dut_pops - p0), 64'd3);
      chk("b2b_dones", 64'(dut_dones - d0), 64'd3);
      if (dut_pop_cyc.size() == 3) begin
         chk("b2b_space01", 64'(dut_pop_cyc[1] - dut_pop_cyc[0]), 64'd3);
         chk("b2b_space12", 64'(dut_pop_cyc[2] - dut_pop_cyc[1]), 64'd3);
      end else begin
         chk("b2b_pop_count", 64'(dut_pop_cyc.size()), 64'd3);
      end

      // reset while the writeback is pending; the in-flight update is dropped
      mem_wr_ready = 1'b0;
      e.set = 8'hc3; e.way = 3'd4; e.evict = 1'b1; e.tag = 12'h777; e.state = INVALID;
      push(e);
      push(rand_entry());
      repeat (2) cycle();
      chk("pre_rst_valid", 64'(mem_wr_valid), 64'd1);
      d0 = dut_dones;
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("rst_mid_memwr");
      mem_wr_ready = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("rst_held");
      have_txn = 1'b0;
      rst = 1'b1;
      repeat (4) cycle();
      chk("rst_no_replay_done", 64'(dut_dones - d0), 64'd1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if (($urandom_range(0, 2) == 0) && (fifo_q.size() < 4)) push(rand_entry());
         mem_wr_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      mem_wr_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if ((fifo_q.size() != 0) || have_txn) cycle();
      end
      chk("drain_done", 64'((fifo_q.size() != 0) || have_txn), 64'd0);
      p0 = dut_pops;
      repeat (3) cycle();
      chk("idle_no_pop", 64'(dut_pops - p0), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
